riscv_mc_control: RTL
=====================

# riscv_mc_control

Multicycle control unit for the RV32 multicycle datapath: RegisterFile, Extend, the three 3-input Multiplex instances and the ALU. A Moore state machine with one Mealy term (branch) steps each instruction through fetch, decode, execute, memory and writeback. It drives every mux select, write enable and ALU operation. It also keeps cycle and retired-instruction counters, and traps on unsupported encodings.

## Interface

Parameters:
- CNT_W, 32, width of cycle_count and instret_count

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- op  in  7  instruction bits [6:0], from the instruction register
- funct3  in  3  instruction bits [14:12]
- funct7b5  in  1  instruction bit 30
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register and oldPC load enable
- RegWrite  out  1  RegisterFile WE3
- ResultSrc  out  2  result mux select: 00 = ALUResult, 01 = data, 10 = ALUOut
- ALUSrcA  out  2  select: 00 = PC, 01 = oldPC, 10 = RD1
- ALUSrcB  out  2  select: 00 = RD2, 01 = immExt, 10 = constant 4
- ALUControl  out  2  00 = add, 01 = sub, 10 = and, 11 = or
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- state  out  4  current state encoding, for debug and verification
- illegal  out  1  high while in TRAP
- cycle_count  out  CNT_W  cycles since reset
- instret_count  out  CNT_W  instructions retired since reset

## Operation

State encodings:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4
- MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9, JAL = 10, TRAP = 11

Supported opcodes:
- lw 0000011, sw 0100011, R-type 0110011, I-type ALU 0010011, beq 1100011, jal 1101111

Transitions:
- FETCH -> DECODE.
- DECODE dispatches on op:
  - lw or sw -> MEMADR
  - R-type -> EXECR
  - I-type -> EXECI
  - beq -> BEQ
  - jal -> JAL
  - any other op -> TRAP
- In DECODE, R-type and I-type also go to TRAP if funct3 is not 000, 110 or 111.
- MEMADR -> MEMREAD when op is lw, otherwise -> MEMWRITE.
- MEMREAD -> MEMWB.
- EXECR -> ALUWB; EXECI -> ALUWB; JAL -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- TRAP is absorbing; only reset leaves it.

Outputs per state (all unlisted outputs are 0):
- FETCH: IRWrite = 1, PCWrite = 1, ALUSrcA = 00, ALUSrcB = 10, ALUControl = add, ResultSrc = 00.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, add. This places the branch/jump target in ALUOut.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, add.
- MEMREAD: AdrSrc = 1, ResultSrc = 10.
- MEMWB: ResultSrc = 01, RegWrite = 1.
- MEMWRITE: AdrSrc = 1, ResultSrc = 10, MemWrite = 1.
- EXECR: ALUSrcA = 10, ALUSrcB = 00; ALUControl decoded from funct3/funct7b5.
- EXECI: ALUSrcA = 10, ALUSrcB = 01; ALUControl decoded from funct3.
- ALUWB: ResultSrc = 10, RegWrite = 1.
- BEQ: ALUSrcA = 10, ALUSrcB = 00, sub, ResultSrc = 10, PCWrite = Zero (combinational).
- JAL: ALUSrcA = 01, ALUSrcB = 10, add, ResultSrc = 10, PCWrite = 1.
- TRAP: illegal = 1; all enables 0.

ALU decode:
- funct3 000 -> add. In EXECR only, funct3 000 with funct7b5 = 1 -> sub.
- funct3 111 -> and.
- funct3 110 -> or.

ImmSrc is decoded combinationally from op in every state:
- lw and I-type -> 00
- sw -> 01
- beq -> 10
- jal -> 11
- other op -> 00

Counters:
- cycle_count increments every cycle reset is low, including TRAP.
- instret_count increments on each transition from MEMWB, MEMWRITE, ALUWB or BEQ into FETCH.
- Both counters wrap from 2^CNT_W−1 to 0 without saturation or flag.

## Timing

Reset behaviour:
- While reset = 1, all enables are forced to 0: PCWrite, IRWrite, RegWrite, MemWrite.
- While reset = 1, illegal = 0 and all selects = 00.
- On the first edge with reset high: state = FETCH (0), cycle_count = 0, instret_count = 0.
- Reset mid-instruction abandons the instruction with no further writes; FETCH follows the edge where reset falls.

Cycles per instruction, counted from FETCH to the next FETCH:
- lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, whether the branch is taken or not.

Signal timing:
- Control outputs are valid combinationally from state after the clock edge.
- The BEQ PCWrite follows Zero within the same cycle.
- The counters are registered; a retirement is visible the cycle after the final state of the instruction.

## Test plan

- Reset held for 2 cycles, then released -> state = 0, counters = 0, no enables during reset; first FETCH shows IRWrite = 1, PCWrite = 1, ALUSrcB = 10.
- Feed op = 0000011 (lw) -> states 0,1,2,3,4,0; RegWrite = 1 only in MEMWB with ResultSrc = 01; instret_count = 1, cycle_count = 5.
- R-type with funct3 = 000, funct7b5 = 1, then sw -> EXECR drives ALUControl = 01; sw asserts MemWrite = 1 exactly once with AdrSrc = 1; instret_count = 2 after 8 cycles.
- beq with Zero = 1, then beq with Zero = 0 -> PCWrite = 1 in BEQ only for the first; each takes 3 cycles.
- op = 1111111 -> TRAP after DECODE, illegal = 1 held for 10 cycles, instret_count unchanged, cycle_count still increments; reset -> FETCH.
- Reset asserted in MEMREAD -> no RegWrite pulse; counters = 0; preload cycle_count to all ones via a long run (or force) -> wraps to 0.

Source files
------------

// File: rtl/riscv_mc_control.sv
// Multicycle RV32 control FSM: steps each instruction through fetch/decode/execute/memory/writeback and traps on bad encodings.
// Latency: control outputs are combinational from state (BEQ PCWrite also follows Zero); the counters are registered.
// Backpressure: none; the FSM advances every cycle, and TRAP holds until reset.
module riscv_mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  state_t state_q;
  state_t state_d;
  logic   f3_ok;
  logic   retire;

  // Only add/sub, and, or are implemented for R-type and I-type ALU ops.
  assign f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
  // Every retiring state returns to FETCH on the next edge.
  assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                  (state_q == S_ALUWB) || (state_q == S_BEQ);
  assign state  = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = f3_ok ? S_EXECR : S_TRAP;
          OP_I:         state_d = f3_ok ? S_EXECI : S_TRAP;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_TRAP;
    endcase
  end

  // Output decode; reset forces every enable and select to zero.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = 2'b00;
    illegal    = 1'b0;
    if (!reset) begin
      case (op)
        OP_SW:   ImmSrc = 2'b01;
        OP_BEQ:  ImmSrc = 2'b10;
        OP_JAL:  ImmSrc = 2'b11;
        default: ImmSrc = 2'b00;
      endcase
      case (state_q)
        S_FETCH: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_DECODE: begin
          // Branch/jump target lands in ALUOut for BEQ/JAL to use.
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_MEMREAD: begin
          AdrSrc    = 1'b1;
          ResultSrc = 2'b10;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc    = 1'b1;
          ResultSrc = 2'b10;
          MemWrite  = 1'b1;
        end
        S_EXECR, S_EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
          case (funct3)
            3'b111:  ALUControl = ALU_AND;
            3'b110:  ALUControl = ALU_OR;
            // funct7b5 selects sub only for register-register ops.
            default: ALUControl = (state_q == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
          endcase
        end
        S_ALUWB: begin
          ResultSrc = 2'b10;
          RegWrite  = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA    = 2'b10;
          ALUControl = ALU_SUB;
          ResultSrc  = 2'b10;
          PCWrite    = Zero;
        end
        S_JAL: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
        S_TRAP:  illegal = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end

  // Free-running cycle counter and retirement counter, both wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      cycle_count <= cycle_count + CNT_W'(1);
      if (retire) instret_count <= instret_count + CNT_W'(1);
    end
  end

endmodule
